// File: rtl/fpmult_assemble_pkg.sv
// Shared single-precision constants and pipeline stage records for the FP multiply
// assemble path.
package fpmult_assemble_pkg;
   localparam int DWIDTH          = 32;
   localparam int EXPONENT        = 8;
   localparam int MANTISSA        = 23;
   localparam int ACTUAL_MANTISSA = 24;
   localparam int BIAS            = 127;
   localparam int EWIDTH          = 10;   // signed exponent, wide enough for 2*254+2
   localparam int STAGES          = 3;
   localparam int PWIDTH          = 2*ACTUAL_MANTISSA;

   localparam logic [DWIDTH-1:0]   QNAN     = 32'h7FC0_0000;
   localparam logic [EXPONENT-1:0] EXP_INF  = 8'hFF;
   localparam logic [MANTISSA-1:0] FRAC_ZERO = '0;

   typedef struct packed {
      logic              sign;
      logic [EWIDTH-1:0] exp;
      logic              zero;
      logic [PWIDTH-1:0] mp;
      logic [4:0]        exc;
   } s1_t;

   typedef struct packed {
      logic                sign;
      logic [EWIDTH-1:0]   exp;
      logic [MANTISSA-1:0] frac;
      logic                inexact;
      logic                zero;
      logic [4:0]          exc;
   } s2_t;
endpackage

// File: rtl/fpmult_round_rne.sv
// Round-to-nearest-even on a normalized fraction; carry signals a fraction wrap
// that the caller folds into the exponent.
module fpmult_round_rne
   import fpmult_assemble_pkg::*;
(
   input  logic                frac_in,
   input  logic [MANTISSA-1:0] frac,
   input  logic                guard,
   input  logic                sticky,
   output logic [MANTISSA-1:0] frac_rnd,
   output logic                carry,
   output logic                inexact
);
   logic inc;

   assign inc                = guard & (sticky | frac[0]) & frac_in;
   assign {carry, frac_rnd}  = {1'b0, frac} + (MANTISSA+1)'(inc);
   assign inexact            = guard | sticky;
endmodule

// File: rtl/fpmult_assemble_module.sv
// Three-stage exponent/normalize/round/pack back end of a single-precision
// multiplier, with a single global stall driven by the output handshake.
module fpmult_assemble_module
   import fpmult_assemble_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic                   Sa,
   input  logic                   Sb,
   input  logic [EXPONENT-1:0]    Ea,
   input  logic [EXPONENT-1:0]    Eb,
   input  logic [PWIDTH-1:0]      Mp,
   input  logic [4:0]             InputExc,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [DWIDTH-1:0]      P,
   output logic [4:0]             Flags
);
   logic              en;
   logic [STAGES:1]   vld_pipe;
   s1_t               s1_d, s1_q;
   s2_t               s2_d, s2_q;
   logic [DWIDTH-1:0] p_d;
   logic [4:0]        flags_d;

   logic                msb, guard, sticky, carry, inexact;
   logic [MANTISSA-1:0] frac_n, frac_r;
   logic                any_exc, nan_c, inf_c;

   assign en        = ~out_valid | out_ready;
   assign in_ready  = en;
   assign out_valid = vld_pipe[STAGES];

   always_comb begin
      s1_d.sign = Sa ^ Sb;
      s1_d.exp  = EWIDTH'(Ea) + EWIDTH'(Eb) - EWIDTH'(BIAS);
      s1_d.zero = (Ea == '0) | (Eb == '0);
      s1_d.mp   = Mp;
      s1_d.exc  = InputExc;
   end

   // A product of two [1,2) values lies in [1,4): bit 47 picks the shift.
   assign msb    = s1_q.mp[PWIDTH-1];
   assign frac_n = msb ? s1_q.mp[PWIDTH-2 -: MANTISSA] : s1_q.mp[PWIDTH-3 -: MANTISSA];
   assign guard  = msb ? s1_q.mp[ACTUAL_MANTISSA-1]    : s1_q.mp[ACTUAL_MANTISSA-2];
   assign sticky = msb ? |s1_q.mp[ACTUAL_MANTISSA-2:0] : |s1_q.mp[ACTUAL_MANTISSA-3:0];

   fpmult_round_rne u_round (
      .frac_in  (1'b1),
      .frac     (frac_n),
      .guard    (guard),
      .sticky   (sticky),
      .frac_rnd (frac_r),
      .carry    (carry),
      .inexact  (inexact)
   );

   always_comb begin
      s2_d.sign    = s1_q.sign;
      s2_d.exp     = s1_q.exp + EWIDTH'(msb) + EWIDTH'(carry);
      s2_d.frac    = frac_r;
      s2_d.inexact = inexact;
      s2_d.zero    = s1_q.zero;
      s2_d.exc     = s1_q.exc;
   end

   // exc = {any, a_nan, b_nan, a_inf, b_inf}; any summarises the other four
   assign any_exc = s2_q.exc[4];
   assign nan_c   = any_exc & (s2_q.exc[3] | s2_q.exc[2] | ((s2_q.exc[1] | s2_q.exc[0]) & s2_q.zero));
   assign inf_c   = any_exc & (s2_q.exc[1] | s2_q.exc[0]);

   always_comb begin
      p_d     = {s2_q.sign, s2_q.exp[EXPONENT-1:0], s2_q.frac};
      flags_d = {4'b0000, s2_q.inexact};
      if (nan_c) begin
         p_d     = QNAN;
         flags_d = 5'b10000;
      end else if (inf_c) begin
         p_d     = {s2_q.sign, EXP_INF, FRAC_ZERO};
         flags_d = 5'b00000;
      end else if (s2_q.zero) begin
         p_d     = {s2_q.sign, {(DWIDTH-1){1'b0}}};
         flags_d = 5'b00010;
      end else if ($signed(s2_q.exp) >= $signed(EWIDTH'(255))) begin
         p_d     = {s2_q.sign, EXP_INF, FRAC_ZERO};
         flags_d = 5'b01001;
      end else if ($signed(s2_q.exp) <= $signed(EWIDTH'(0))) begin
         p_d     = {s2_q.sign, {(DWIDTH-1){1'b0}}};
         flags_d = 5'b00111;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
         P        <= '0;
         Flags    <= '0;
      end else if (en) begin
         vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         P        <= p_d;
         Flags    <= flags_d;
      end
   end
endmodule

// File: tb/tb_fpmult_assemble_module.sv
// Directed vectors with a queue scoreboard; a negedge monitor pushes on input
// transfer, pops on output transfer and watches stall/reset behaviour.
module tb_fpmult_assemble_module;
   logic        clk = 1'b0;
   logic        rst, in_valid, in_ready, Sa, Sb, out_valid, out_ready;
   logic [7:0]  Ea, Eb;
   logic [47:0] Mp;
   logic [4:0]  InputExc, Flags;
   logic [31:0] P;

   fpmult_assemble_module dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .Sa(Sa), .Sb(Sb), .Ea(Ea), .Eb(Eb), .Mp(Mp), .InputExc(InputExc),
      .out_valid(out_valid), .out_ready(out_ready), .P(P), .Flags(Flags)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       nm;
      logic [31:0] p;
      logic [4:0]  f;
      int          issue;
      bit          chk_lat;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0, n_err = 0, cyc = 0;
   string       cur_nm;
   logic [31:0] cur_p;
   logic [4:0]  cur_f;
   bit          cur_lat;
   bit          rst_seen = 0, stalled = 0;
   logic [31:0] hold_p;
   logic [4:0]  hold_f;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      n_cmp++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, act, req);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (rst) begin
         sb.delete();
         stalled  = 0;
         rst_seen = 1;
      end else begin
         if (rst_seen) begin
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_P",         64'(P),         64'd0);
            chk("rst_Flags",     64'(Flags),     64'd0);
            chk("rst_in_ready",  64'(in_ready),  64'd1);
            rst_seen = 0;
         end
         if (stalled) begin
            chk("stall_P_hold",     64'(P),         64'(hold_p));
            chk("stall_Flags_hold", 64'(Flags),     64'(hold_f));
            chk("stall_valid_hold", 64'(out_valid), 64'd1);
         end
         if (out_valid && !out_ready) begin
            chk("stall_in_ready", 64'(in_ready), 64'd0);
            stalled = 1;
            hold_p  = P;
            hold_f  = Flags;
         end else begin
            stalled = 0;
         end
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               chk("unexpected_output", 64'(P), 64'hDEAD);
            end else begin
               e = sb.pop_front();
               chk({e.nm, "_P"},     64'(P),     64'(e.p));
               chk({e.nm, "_Flags"}, 64'(Flags), 64'(e.f));
               if (e.chk_lat) chk({e.nm, "_latency"}, 64'(cyc - e.issue), 64'd3);
            end
         end
         if (in_valid && in_ready) begin
            e.nm = cur_nm; e.p = cur_p; e.f = cur_f; e.issue = cyc; e.chk_lat = cur_lat;
            sb.push_back(e);
         end
      end
   end

   task automatic send(input string nm, input logic sa, input logic sb_i,
                       input logic [7:0] ea, input logic [7:0] eb, input logic [47:0] mp,
                       input logic [4:0] exc, input logic [31:0] p, input logic [4:0] f,
                       input bit lat);
      bit acc = 0;
      Sa = sa; Sb = sb_i; Ea = ea; Eb = eb; Mp = mp; InputExc = exc;
      cur_nm = nm; cur_p = p; cur_f = f; cur_lat = lat;
      in_valid = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk); acc = in_ready;
         @(posedge clk); #1;
         if (acc) break;
      end
      if (!acc) chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
      in_valid = 1'b0;
   endtask

   task automatic drain(input string nm);
      int k = 0;
      while (sb.size() != 0 && k < 60) begin
         @(posedge clk); #1; k++;
      end
      chk({nm, "_drained"}, 64'(sb.size()), 64'd0);
      repeat (4) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      Sa = 0; Sb = 0; Ea = 0; Eb = 0; Mp = 0; InputExc = 0;
      cur_nm = "none"; cur_p = 0; cur_f = 0; cur_lat = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // basic function, one at a time
      send("mul_3",     0, 0, 8'h7F, 8'h80, 48'h6000_0000_0000, 5'b00000, 32'h4040_0000, 5'b00000, 1);
      drain("single");
      send("tie_even",  0, 0, 8'h7F, 8'h7F, 48'h4000_0040_0000, 5'b00000, 32'h3F80_0000, 5'b00001, 1);
      send("tie_odd",   0, 0, 8'h7F, 8'h7F, 48'h4000_00C0_0000, 5'b00000, 32'h3F80_0002, 5'b00001, 1);
      send("round_up",  0, 0, 8'h7F, 8'h7F, 48'h4000_0060_0000, 5'b00000, 32'h3F80_0001, 5'b00001, 1);
      send("rnd_carry", 0, 0, 8'h7F, 8'h7F, 48'h7FFF_FFC0_0000, 5'b00000, 32'h4000_0000, 5'b00001, 1);
      send("msb_norm",  0, 0, 8'h7F, 8'h7F, 48'hC000_0080_0000, 5'b00000, 32'h4040_0000, 5'b00001, 1);
      send("ovf",       1, 0, 8'hFE, 8'hFE, 48'h4000_0000_0000, 5'b00000, 32'hFF80_0000, 5'b01001, 1);
      send("unf",       0, 0, 8'h01, 8'h01, 48'h4000_0000_0000, 5'b00000, 32'h0000_0000, 5'b00111, 1);
      send("e254",      0, 0, 8'hFE, 8'h7F, 48'h4000_0000_0000, 5'b00000, 32'h7F00_0000, 5'b00000, 1);
      send("e255",      0, 0, 8'hFE, 8'h7F, 48'h8000_0000_0000, 5'b00000, 32'h7F80_0000, 5'b01001, 1);
      send("e0",        0, 0, 8'h40, 8'h3F, 48'h4000_0000_0000, 5'b00000, 32'h0000_0000, 5'b00111, 1);
      send("e1",        0, 0, 8'h40, 8'h3F, 48'h8000_0000_0000, 5'b00000, 32'h0080_0000, 5'b00000, 1);
      send("nan_a",     0, 0, 8'h7F, 8'h7F, 48'h4000_0000_0000, 5'b11000, 32'h7FC0_0000, 5'b10000, 1);
      send("inf_zero",  0, 0, 8'hFF, 8'h00, 48'h4000_0000_0000, 5'b10010, 32'h7FC0_0000, 5'b10000, 1);
      send("inf",       1, 0, 8'hFF, 8'h80, 48'h4000_0000_0000, 5'b10010, 32'hFF80_0000, 5'b00000, 1);
      send("zero",      1, 0, 8'h00, 8'h80, 48'h4000_0000_0000, 5'b00000, 32'h8000_0000, 5'b00010, 1);
      drain("stream1");

      // back-to-back stream with a 3-cycle output stall
      fork
         begin
            send("s0", 0, 0, 8'h7F, 8'h80, 48'h6000_0000_0000, 5'b00000, 32'h4040_0000, 5'b00000, 0);
            send("s1", 0, 0, 8'h7F, 8'h7F, 48'h4000_00C0_0000, 5'b00000, 32'h3F80_0002, 5'b00001, 0);
            send("s2", 1, 0, 8'hFE, 8'hFE, 48'h4000_0000_0000, 5'b00000, 32'hFF80_0000, 5'b01001, 0);
            send("s3", 0, 0, 8'h01, 8'h01, 48'h4000_0000_0000, 5'b00000, 32'h0000_0000, 5'b00111, 0);
            send("s4", 0, 0, 8'h7F, 8'h7F, 48'h4000_0000_0000, 5'b11000, 32'h7FC0_0000, 5'b10000, 0);
            send("s5", 0, 0, 8'h7F, 8'h7F, 48'h7FFF_FFC0_0000, 5'b00000, 32'h4000_0000, 5'b00001, 0);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain("stall");

      // reset with operands in flight: they must vanish
      send("r0", 0, 0, 8'h7F, 8'h80, 48'h6000_0000_0000, 5'b00000, 32'h4040_0000, 5'b00000, 0);
      send("r1", 0, 0, 8'h7F, 8'h7F, 48'h4000_0040_0000, 5'b00000, 32'h3F80_0000, 5'b00001, 0);
      send("r2", 1, 0, 8'hFE, 8'hFE, 48'h4000_0000_0000, 5'b00000, 32'hFF80_0000, 5'b01001, 0);
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      send("post_rst0", 0, 0, 8'h40, 8'h3F, 48'h8000_0000_0000, 5'b00000, 32'h0080_0000, 5'b00000, 1);
      send("post_rst1", 1, 0, 8'h00, 8'h80, 48'h4000_0000_0000, 5'b00000, 32'h8000_0000, 5'b00010, 1);
      drain("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fpmult_assemble_module.md
FPMULT_ASSEMBLE_MODULE -- requirements
Module: fpmult_assemble_module

Interface
REQ-001 Parameters SHALL come from shared defines:
- DWIDTH, 32, word width.
- EXPONENT, 8, exponent width.
- MANTISSA, 23, stored fraction width.
- ACTUAL_MANTISSA, 24, fraction width with hidden bit.
- BIAS, 127, exponent bias.
REQ-002 The block SHALL have one clock; reset is synchronous and active-high. Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input operands valid.
- in_ready  out  1  block accepts input this cycle.
- Sa  in  1  sign of A.
- Sb  in  1  sign of B.
- Ea  in  EXPONENT  biased exponent of A.
- Eb  in  EXPONENT  biased exponent of B.
- Mp  in  2*ACTUAL_MANTISSA  full unsigned product of {1,Ma} and {1,Mb}.
- InputExc  in  5  {any, ANaN, BNaN, AInf, BInf}.
- out_valid  out  1  P and Flags valid.
- out_ready  in  1  downstream accepts result.
- P  out  DWIDTH  packed IEEE-754 single-precision product.
- Flags  out  5  {invalid, overflow, underflow, zero, inexact}.

Function
REQ-003 The block SHALL be a 3-stage pipeline with global enable en = ~out_valid | out_ready, and in_ready SHALL equal en.
- A transfer occurs on in_valid & in_ready.
- Latency SHALL be exactly 3 cycles with out_ready held high.
- Sustained throughput SHALL be 1 result per cycle.
REQ-004 When en=0, all stage registers, P, Flags and out_valid SHALL hold.
- Bubbles (in_valid=0) SHALL propagate as valid=0.
REQ-005 Stage 1 SHALL register:
- sign = Sa^Sb.
- 10-bit signed exponent E = Ea + Eb - BIAS.
- zero flag = (Ea==0)|(Eb==0); denormals are flushed to zero.
- Mp and InputExc.
REQ-006 Stage 2 SHALL normalize and round:
- If Mp[47]=1: fraction = Mp[46:24], guard = Mp[23], sticky = |Mp[22:0], and E SHALL increment by 1.
- Else: fraction = Mp[45:23], guard = Mp[22], sticky = |Mp[21:0].
REQ-007 Rounding SHALL be round-to-nearest-even.
- Increment when guard & (sticky | fraction[0]).
- A carry out of the fraction SHALL zero the fraction and add 1 to E.
- inexact = guard | sticky.
REQ-008 Stage 3 SHALL select the result in this priority order:
- Either NaN, or Inf with zero: P = 0x7FC00000, invalid=1.
- Either Inf: P = {sign, 0xFF, 0}.
- zero: P = {sign, 31'b0}, zero=1.
- E >= 255: P = {sign, 0xFF, 0}, overflow=1, inexact=1.
- E <= 0: P = {sign, 31'b0}, underflow=1, zero=1, inexact=1.
- Otherwise: P = {sign, E[7:0], fraction}.
REQ-009 Flags not named in the selected case SHALL be 0; inexact SHALL be 0 for NaN, Inf and zero results.
REQ-010 All arithmetic SHALL be unsigned except E, which SHALL be 10-bit two's-complement so that under- and overflow are detected without wrap.

Reset
REQ-011 rst SHALL clear all stage valid bits and out_valid to 0, and P and Flags to 0, on the next clk edge.
REQ-012 rst SHALL take priority over en; in-flight operands SHALL be discarded.
REQ-013 in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-014 DWIDTH, EXPONENT, MANTISSA, ACTUAL_MANTISSA, BIAS and the canonical NaN/Inf constants SHALL live in the shared FP define header.
REQ-015 Stage 2 rounding SHALL be one sub-module, fpmult_round_rne: combinational; inputs fraction, guard, sticky; outputs rounded fraction, carry, inexact.

Verification
REQ-016 Ea=0x7F, Eb=0x80, Mp=0x600000000000, Sa=Sb=0 -> P=0x40400000, Flags=0, out_valid exactly 3 cycles later.
REQ-017 Ea=Eb=0x7F, Mp=0x4000_0040_0000 -> P=0x3F800000 (tie, round to even), inexact=1. Same exponents with Mp=0x4000_00C0_0000 -> P=0x3F800002, inexact=1.
REQ-018 Ea=Eb=0xFE, Mp=0x400000000000, Sa=1, Sb=0 -> P=0xFF800000, Flags=5'b01001. Ea=Eb=0x01 -> P=0x00000000, Flags=5'b00111.
REQ-019 InputExc=5'b11000 -> P=0x7FC00000, Flags=5'b10000. InputExc=5'b10010 with Eb=0 -> P=0x7FC00000.
REQ-020 Stream of 6 back-to-back inputs with out_ready low for cycles 4-6 -> P held stable, in_ready=0 while stalled, no result lost or duplicated. Assert rst mid-stream -> out_valid=0 the next cycle, and no stale results appear afterwards.
